// File: rtl/ps2_pkg.sv
// Shared PS/2 frame constants and types for the keyboard receiver.
package ps2_pkg;
    localparam int PS2_FRAME_BITS = 11;
    localparam int START          = 0;
    localparam int DATA_LSB       = 1;
    localparam int PARITY         = 9;
    localparam int STOP           = 10;

    typedef logic [7:0] ps2_byte_t;
endpackage

// File: rtl/ps2_rx_fifo.sv
// Scan-code FIFO: power-of-two depth, extra pointer MSB separates full from empty.
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int FIFO_AW = 3
) (
    input  logic      clk,
    input  logic      resetn,
    input  logic      push,
    input  logic      pop,
    input  ps2_byte_t din,
    output ps2_byte_t dout,
    output logic      full,
    output logic      empty
);
    ps2_byte_t        mem [2**FIFO_AW];
    logic [FIFO_AW:0] wr_ptr;
    logic [FIFO_AW:0] rd_ptr;
    logic             pop_acc;
    logic             push_acc;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]) &&
                      (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]);
    assign pop_acc  = pop && !empty;
    // A pop in the same cycle frees the slot the push lands in.
    assign push_acc = push && (!full || pop_acc);
    assign dout     = empty ? '0 : mem[rd_ptr[FIFO_AW-1:0]];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_acc) wr_ptr <= wr_ptr + 1'b1;
            if (pop_acc)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_acc) mem[wr_ptr[FIFO_AW-1:0]] <= din;
    end
endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronise, deframe 11-bit frames, queue bytes.
// Define PS2_FRAME_CHECK_EN to drop frames with bad start/stop/parity.
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int FIFO_AW     = 3,
    parameter int SYNC_STAGES = 3
) (
    input  logic      clk,
    input  logic      resetn,
    input  logic      ps2_clk,
    input  logic      ps2_data,
    input  logic      nextdata_n,
    output ps2_byte_t data,
    output logic      ready,
    output logic      overflow
);
    logic [SYNC_STAGES-1:0]    clk_sync;
    logic [SYNC_STAGES-1:0]    dat_sync;
    logic [3:0]                bit_cnt;
    logic [PS2_FRAME_BITS-2:0] shreg;
    logic [PS2_FRAME_BITS-1:0] frame;
    logic                      fall;
    logic                      bit_in;
    logic                      last;
    logic                      frame_ok;
    logic                      push;
    logic                      pop;
    logic                      full;
    logic                      empty;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            clk_sync <= '1;
            dat_sync <= '1;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_data};
        end
    end

    assign fall   = clk_sync[SYNC_STAGES-1] && !clk_sync[SYNC_STAGES-2];
    assign bit_in = dat_sync[SYNC_STAGES-1];
    assign last   = fall && (bit_cnt == 4'(PS2_FRAME_BITS - 1));

    // Bits enter at the top and shift down, so the start bit ends in shreg[0].
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bit_cnt <= '0;
            shreg   <= '0;
        end else if (fall) begin
            bit_cnt <= last ? 4'd0 : bit_cnt + 4'd1;
            shreg   <= {bit_in, shreg[PS2_FRAME_BITS-2:1]};
        end
    end

    // Stop bit is taken straight from the synchroniser on the completion cycle.
    assign frame = {bit_in, shreg};

`ifdef PS2_FRAME_CHECK_EN
    assign frame_ok = !frame[START] && frame[STOP] && (^frame[PARITY:DATA_LSB]);
`else
    logic unused_frame_bits;
    assign unused_frame_bits = ^{frame[START], frame[PARITY], frame[STOP]};
    assign frame_ok = 1'b1;
`endif

    assign push  = last && frame_ok;
    assign pop   = !nextdata_n;
    assign ready = !empty;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)               overflow <= 1'b0;
        else if (pop && !empty)    overflow <= 1'b0;
        else if (push && full)     overflow <= 1'b1;
    end

    ps2_rx_fifo #(.FIFO_AW(FIFO_AW)) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push),
        .pop    (pop),
        .din    (frame[DATA_LSB +: 8]),
        .dout   (data),
        .full   (full),
        .empty  (empty)
    );
endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Bench for ps2_keyboard_rx: vector table, corner sequences, random frames vs queue model.
module tb_ps2_keyboard_rx;
    localparam int S     = 3;
    localparam int HALF  = 20;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       nextdata_n = 1'b1;
    logic [7:0] data;
    logic       ready;
    logic       overflow;

    always #5 clk = ~clk;

    ps2_keyboard_rx #(.FIFO_AW(3), .SYNC_STAGES(S)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .nextdata_n (nextdata_n),
        .data       (data),
        .ready      (ready),
        .overflow   (overflow)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0] q[$];
    bit m_ovf = 1'b0;

    typedef struct {
        logic [7:0] b;
        bit         flip;
        bit         exp_ready;
        logic [7:0] exp_data;
    } vec_t;
    vec_t tv[6];

`ifdef PS2_FRAME_CHECK_EN
    localparam bit BAD_PUSHED = 1'b0;
`else
    localparam bit BAD_PUSHED = 1'b1;
`endif

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_state(input string nm);
        chk({nm, ".ready"}, 32'(ready), 32'(q.size() != 0));
        chk({nm, ".overflow"}, 32'(overflow), 32'(m_ovf));
        if (q.size() != 0) chk({nm, ".data"}, 32'(data), 32'(q[0]));
    endtask

    // Reference: a frame either lands in the queue, or sets overflow when 8 are held.
    task automatic model_frame(input logic [7:0] b, input bit flip, input bit pop);
        if (pop && q.size() != 0) begin
            void'(q.pop_front());
            m_ovf = 1'b0;
        end
        if (!flip || BAD_PUSHED) begin
            if (q.size() < DEPTH) q.push_back(b);
            else                  m_ovf = 1'b1;
        end
    endtask

    task automatic pop_one();
        nextdata_n = 1'b0;
        @(negedge clk);
        nextdata_n = 1'b1;
        if (q.size() != 0) begin
            void'(q.pop_front());
            m_ovf = 1'b0;
        end
    endtask

    // The completion cycle is S-1 clk edges after ps2_clk falls; push lands on edge S.
    task automatic send_frame(input logic [7:0] b, input bit flip, input int nbits,
                              input bit pop_done, input bit lat);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ flip, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            if (i == 10) begin
                repeat (S - 1) @(negedge clk);
                if (lat) chk("latency.pre", 32'(ready), 32'd0);
                if (pop_done) nextdata_n = 1'b0;
                @(negedge clk);
                nextdata_n = 1'b1;
                model_frame(b, flip, pop_done);
                if (lat) check_state("latency.post");
                repeat (HALF - S) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    initial begin
        tv[0] = '{8'h1C, 1'b0, 1'b1, 8'h1C};
        tv[1] = '{8'h00, 1'b0, 1'b1, 8'h00};
        tv[2] = '{8'hFF, 1'b0, 1'b1, 8'hFF};
        tv[3] = '{8'hF0, 1'b0, 1'b1, 8'hF0};
        tv[4] = '{8'h1C, 1'b1, BAD_PUSHED, 8'h1C};
        tv[5] = '{8'h80, 1'b1, BAD_PUSHED, 8'h80};

        repeat (3) @(negedge clk);
        chk("reset.ready", 32'(ready), 32'd0);
        chk("reset.overflow", 32'(overflow), 32'd0);
        chk("reset.data", 32'(data), 32'd0);
        resetn = 1'b1;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            send_frame(tv[i].b, tv[i].flip, 11, 1'b0, 1'b1);
            chk($sformatf("vec%0d.ready", i), 32'(ready), 32'(tv[i].exp_ready));
            if (tv[i].exp_ready) chk($sformatf("vec%0d.data", i), 32'(data), 32'(tv[i].exp_data));
            pop_one();
            chk($sformatf("vec%0d.popped", i), 32'(ready), 32'd0);
        end

        send_frame(8'hF0, 1'b0, 11, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 11, 1'b0, 1'b0);
        chk("two.first", 32'(data), 32'hF0);
        pop_one();
        chk("two.second", 32'(data), 32'h1C);
        pop_one();
        chk("two.empty", 32'(ready), 32'd0);

        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 11, 1'b0, 1'b0);
        chk("ovf.set", 32'(overflow), 32'd1);
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("ovf.pop%0d", i), 32'(data), 32'(i));
            pop_one();
            chk($sformatf("ovf.clr%0d", i), 32'(overflow), 32'd0);
        end
        chk("ovf.empty", 32'(ready), 32'd0);

        for (int i = 1; i <= 9; i++) send_frame(8'(8'h20 + i), 1'b0, 11, i == 9, 1'b0);
        chk("simul.ovf", 32'(overflow), 32'd0);
        chk("simul.head", 32'(data), 32'h22);
        for (int i = 0; i < 8; i++) begin
            check_state($sformatf("simul.e%0d", i));
            pop_one();
        end
        chk("simul.empty", 32'(ready), 32'd0);

        send_frame(8'h33, 1'b0, 11, 1'b0, 1'b0);
        send_frame(8'h5A, 1'b0, 5, 1'b0, 1'b0);
        resetn = 1'b0;
        @(negedge clk);
        chk("rstmid.ready", 32'(ready), 32'd0);
        chk("rstmid.overflow", 32'(overflow), 32'd0);
        chk("rstmid.data", 32'(data), 32'd0);
        q.delete();
        m_ovf = 1'b0;
        resetn = 1'b1;
        repeat (4) @(negedge clk);
        send_frame(8'h5A, 1'b0, 11, 1'b0, 1'b1);
        chk("rstmid.after", 32'(data), 32'h5A);
        pop_one();

        for (int n = 0; n < 30; n++) begin
            logic [7:0] b;
            bit flip;
            b = 8'($urandom);
            flip = ($urandom_range(0, 3) == 0);
            send_frame(b, flip, 11, 1'b0, 1'b0);
            check_state($sformatf("rnd%0d", n));
            repeat ($urandom_range(0, 1)) begin
                pop_one();
                check_state($sformatf("rnd%0d.pop", n));
            end
        end
        while (q.size() != 0) begin
            pop_one();
            check_state("drain");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
